prescaled_tick_timer: RTL and testbench

Consumes the square-wave output of the clock prescaler and converts each rising edge into a single-cycle tick in the fast `clk` domain. Counts those ticks against a programmable interval and raises a held event for the downstream mood/behaviour logic. Supports periodic or one-shot operation, with an ack handshake and a sticky overrun flag. Sits directly downstream of the prescaler; all logic runs on the undivided system clock.

---
 rtl/prescaled_tick_timer_if.sv | 45 ++++
 rtl/prescaled_tick_timer.sv | 145 ++++++++++++++
 tb/tb_prescaled_tick_timer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prescaled_tick_timer_if.sv
// prescaled_tick_timer_if
//   Bundles the timer's data and handshake signals so the timer and its
//   driver share one connection.
//
//   Handshake: event_valid is raised by the timer and held until the consumer
//   asserts ack while event_valid is high; the clear takes effect on the next
//   clk edge. An ack while event_valid is low has no effect.
//
//   Signals (slave = timer side):
//     presc_clk   in   prescaler square wave
//     interval    in   ticks per event, sampled on start
//     oneshot     in   1 = stop after one event, sampled on start
//     start       in   load-and-run pulse
//     stop        in   abort pulse
//     ack         in   consumer acknowledge of event_valid
//     tick        out  one-cycle pulse per presc_clk rising edge
//     event_valid out  interval expired, held until acked
//     overrun     out  sticky: expiry while the previous event was unacked
//     busy        out  timer is counting
//     count       out  remaining ticks to next expiry
interface prescaled_tick_timer_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 presc_clk;
   logic [CNT_WIDTH-1:0] interval;
   logic                 oneshot;
   logic                 start;
   logic                 stop;
   logic                 ack;
   logic                 tick;
   logic                 event_valid;
   logic                 overrun;
   logic                 busy;
   logic [CNT_WIDTH-1:0] count;

   modport master (
      output presc_clk, interval, oneshot, start, stop, ack,
      input  tick, event_valid, overrun, busy, count
   );

   modport slave (
      input  presc_clk, interval, oneshot, start, stop, ack,
      output tick, event_valid, overrun, busy, count
   );
endinterface

// File: rtl/prescaled_tick_timer.sv
// prescaled_tick_timer
//   Turns each rising edge of the prescaler output into a one-cycle tick in
//   the clk domain, counts ticks against a programmable interval and raises a
//   held event (periodic or one-shot) with ack handshake and sticky overrun.
//
//   Ports:
//     clk     in   system clock (same clock as the prescaler)
//     rst     in   asynchronous active-high reset
//     bus     slave modport of prescaled_tick_timer_if
//     state_o out  current FSM state (0 = IDLE, 1 = RUN)
//
//   Optional feature macro: PRESCALED_TICK_TIMER_SYNC_EN
//     defined   -> presc_clk goes through a 2-flop synchronizer first
//     undefined -> presc_clk must come from a clk-domain register
module prescaled_tick_timer #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   prescaled_tick_timer_if.slave bus,
   output logic                  state_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] ival_q, ival_d;
   logic                 oneshot_q, oneshot_d;
   logic                 ev_q, ev_d;
   logic                 ovr_q, ovr_d;
   logic                 p_q;
   logic                 tick_q, tick_d;
   logic                 presc_s;

`ifdef PRESCALED_TICK_TIMER_SYNC_EN
   localparam int ARM_STAGES = 3;
   logic [1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], bus.presc_clk};
   end

   assign presc_s = sync_q[1];
`else
   localparam int ARM_STAGES = 1;
   assign presc_s = bus.presc_clk;
`endif

   // The edge detector is only armed once p_q holds a real sample taken after
   // reset; otherwise a presc_clk already high at release would look like a
   // rising edge against the reset value of p_q.
   logic [ARM_STAGES-1:0] arm_q;

   assign tick_d = presc_s & ~p_q & arm_q[ARM_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arm_q  <= '0;
         p_q    <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         arm_q  <= ARM_STAGES'({arm_q, 1'b1});
         p_q    <= presc_s;
         tick_q <= tick_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         ival_q    <= '0;
         oneshot_q <= 1'b0;
         ev_q      <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         ival_q    <= ival_d;
         oneshot_q <= oneshot_d;
         ev_q      <= ev_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      ival_d    = ival_q;
      oneshot_d = oneshot_q;
      ev_d      = ev_q;
      ovr_d     = ovr_q;

      if (bus.ack && ev_q) ev_d = 1'b0;

      if (bus.stop) begin
         // stop has priority over a simultaneous start
         state_d = IDLE;
         count_d = '0;
      end else if (bus.start) begin
         if (bus.interval != '0) begin
            state_d   = RUN;
            count_d   = bus.interval;
            ival_d    = bus.interval;
            oneshot_d = bus.oneshot;
            ovr_d     = 1'b0;
         end else if (state_q == RUN) begin
            // restart with a zero interval aborts the run
            state_d   = IDLE;
            count_d   = '0;
            oneshot_d = bus.oneshot;
            ovr_d     = 1'b0;
         end
         // any tick in this cycle is dropped
      end else if (state_q == RUN && tick_q) begin
         if (count_q > CNT_WIDTH'(1)) begin
            count_d = count_q - CNT_WIDTH'(1);
         end else if (count_q == CNT_WIDTH'(1)) begin
            // an unacked pending event turns this expiry into an overrun;
            // an ack in the same cycle is consumed by the new event instead
            if (ev_q && !bus.ack) ovr_d = 1'b1;
            ev_d = 1'b1;
            if (oneshot_q) begin
               count_d = '0;
               state_d = IDLE;
            end else begin
               count_d = ival_q;
            end
         end
      end
   end

   assign bus.tick        = tick_q;
   assign bus.event_valid = ev_q;
   assign bus.overrun     = ovr_q;
   assign bus.busy        = (state_q == RUN);
   assign bus.count       = count_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_prescaled_tick_timer.sv
module tb_prescaled_tick_timer;
   logic clk;
   logic rst;
   logic state_dbg;
   int   checks;
   int   errors;
   logic seen_tick;
   logic seen_tick2;

   prescaled_tick_timer_if #(.CNT_WIDTH(8)) bus ();

   prescaled_tick_timer #(.CNT_WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One DIV=4 presc_clk period: high 2 cycles, low 2 cycles.
   // Optionally asserts ack during the cycle in which tick is high.
   task automatic period(input bit ack_on_tick);
      bus.presc_clk = 1'b1;
      step();
      seen_tick = bus.tick;
      if (ack_on_tick) bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      seen_tick2 = bus.tick;
      bus.presc_clk = 1'b0;
      step();
      step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      seen_tick     = 1'b0;
      seen_tick2    = 1'b0;
      rst           = 1'b1;
      bus.presc_clk = 1'b0;
      bus.interval  = '0;
      bus.oneshot   = 1'b0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.ack       = 1'b0;
      step();
      step();

      // reset state
      chk("rst_tick", bus.tick, 0);
      chk("rst_event", bus.event_valid, 0);
      chk("rst_overrun", bus.overrun, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_state", state_dbg, 0);
      rst = 1'b0;
      step();

      // tick generation, idle
      bus.presc_clk = 1'b1;
      step();
      chk("tick_first", bus.tick, 1);
      step();
      chk("tick_width", bus.tick, 0);
      step();
      chk("tick_held_high", bus.tick, 0);
      bus.presc_clk = 1'b0;
      step();
      step();
      chk("tick_low", bus.tick, 0);
      period(1'b0);
      chk("tick_period", seen_tick, 1);
      chk("tick_period_end", seen_tick2, 0);
      chk("idle_count", bus.count, 0);
      chk("idle_busy", bus.busy, 0);

      // periodic interval=3 with ack; interval changed during run is ignored
      bus.interval = 8'd3;
      bus.oneshot  = 1'b0;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      bus.interval = 8'd7;
      chk("p3_busy", bus.busy, 1);
      chk("p3_load", bus.count, 3);
      period(1'b0);
      chk("p3_count2", bus.count, 2);
      chk("p3_noev", bus.event_valid, 0);
      period(1'b0);
      chk("p3_count1", bus.count, 1);
      period(1'b0);
      chk("p3_ev1", bus.event_valid, 1);
      chk("p3_reload1", bus.count, 3);
      chk("p3_ovr1", bus.overrun, 0);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("p3_acked", bus.event_valid, 0);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("p3_ack_idle_ev", bus.event_valid, 0);
      period(1'b0);
      period(1'b0);
      chk("p3_count1b", bus.count, 1);
      period(1'b0);
      chk("p3_ev2", bus.event_valid, 1);
      chk("p3_reload2", bus.count, 3);
      chk("p3_ovr2", bus.overrun, 0);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("stop_busy", bus.busy, 0);
      chk("stop_count", bus.count, 0);

      // periodic interval=2, never ack -> overrun
      bus.interval = 8'd2;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      chk("p2_load", bus.count, 2);
      period(1'b0);
      period(1'b0);
      chk("p2_ev", bus.event_valid, 1);
      chk("p2_ovr0", bus.overrun, 0);
      chk("p2_reload", bus.count, 2);
      period(1'b0);
      period(1'b0);
      chk("p2_ev_held", bus.event_valid, 1);
      chk("p2_ovr1", bus.overrun, 1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("restart_ovr", bus.overrun, 0);
      chk("restart_count", bus.count, 2);
      chk("restart_ev", bus.event_valid, 1);
      chk("restart_busy", bus.busy, 1);

      // expiry and ack in the same cycle
      period(1'b0);
      chk("same_pre", bus.count, 1);
      period(1'b1);
      chk("same_ev", bus.event_valid, 1);
      chk("same_ovr", bus.overrun, 0);
      chk("same_count", bus.count, 2);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      chk("same_acked", bus.event_valid, 0);

      // start and stop together during run
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("ss_busy", bus.busy, 0);
      chk("ss_count", bus.count, 0);

      // one-shot interval=1
      bus.interval = 8'd1;
      bus.oneshot  = 1'b1;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      chk("os_busy", bus.busy, 1);
      chk("os_load", bus.count, 1);
      period(1'b0);
      chk("os_ev", bus.event_valid, 1);
      chk("os_busy_after", bus.busy, 0);
      chk("os_count_after", bus.count, 0);
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      period(1'b0);
      chk("os_no_more_ev", bus.event_valid, 0);
      chk("os_still_tick", seen_tick, 1);

      // start with interval=0 is ignored
      bus.interval = 8'd0;
      bus.oneshot  = 1'b0;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      chk("zero_busy", bus.busy, 0);
      chk("zero_count", bus.count, 0);
      chk("zero_state", state_dbg, 0);

      // asynchronous reset mid-run
      bus.interval = 8'd5;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      for (int i = 0; i < 5; i++) period(1'b0);
      chk("pre_rst_ev", bus.event_valid, 1);
      chk("pre_rst_count", bus.count, 5);
      rst = 1'b1;
      #1;
      chk("arst_tick", bus.tick, 0);
      chk("arst_ev", bus.event_valid, 0);
      chk("arst_ovr", bus.overrun, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_count", bus.count, 0);

      // presc_clk already high when reset releases
      bus.presc_clk = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("rel_high_tick1", bus.tick, 0);
      step();
      chk("rel_high_tick2", bus.tick, 0);
      bus.presc_clk = 1'b0;
      step();
      step();
      period(1'b0);
      chk("post_rst_tick", seen_tick, 1);
      chk("post_rst_ev", bus.event_valid, 0);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_count", bus.count, 0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
